// File: rtl/inert_spi_seq_if.sv
// ============================================================================
// Module : inert_spi_seq_if
// Brief  : Command/response bus between the inertial sequencer and SPI monarch.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface inert_spi_seq_if;
    logic        wrt;
    logic [15:0] cmd;
    logic        done;
    logic [15:0] rd_data;

    modport master (output wrt, output cmd, input done, input rd_data);
    modport slave  (input wrt, input cmd, output done, output rd_data);
endinterface

`default_nettype wire

// File: rtl/inert_spi_seq.sv
// ============================================================================
// Module : inert_spi_seq
// Brief  : Power-up wait, three sensor config writes, then INT-driven yaw-rate
//          read pairs assembled into a signed 16-bit sample.
//          Optional INERT_TIMEOUT_EN: watchdog on WAIT_INT that replays config.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module inert_spi_seq #(
    parameter int          PWR_W = 16,
    parameter logic [15:0] CFG0  = 16'h0D02,
    parameter logic [15:0] CFG1  = 16'h1160,
    parameter logic [15:0] CFG2  = 16'h1460,
    parameter logic [15:0] RD_LO = 16'hA600,
    parameter logic [15:0] RD_HI = 16'hA700
`ifdef INERT_TIMEOUT_EN
    ,
    parameter int          TO_W  = 20
`endif
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          INT,
    inert_spi_seq_if.master    bus,
    output logic [15:0]        yaw_rt,
    output logic               vld,
    output logic               cfg_done,
    output logic               to_err
);

    typedef enum logic [2:0] {
        S_PWR  = 3'd0,
        S_CFG0 = 3'd1,
        S_CFG1 = 3'd2,
        S_CFG2 = 3'd3,
        S_WAIT = 3'd4,
        S_RD_L = 3'd5,
        S_RD_H = 3'd6
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [PWR_W-1:0]   r_pwr_cnt;
    logic [1:0]         r_int_sync;
    logic               r_done_ff;
    logic               r_wrt;
    logic [15:0]        r_cmd;
    logic [7:0]         r_lo;
    logic [15:0]        r_yaw;
    logic               r_vld;
    logic               r_cfg_done;

    logic               w_done_rise;
    logic               w_int;
    logic               w_wrt;
    logic [15:0]        w_cmd;
    logic               w_lo_ld;
    logic               w_yaw_ld;
    logic               w_cfg_set;
    logic               w_cfg_clr;
    logic               w_to_set;
    logic               w_to_hit;
    logic               w_unused_rd_hi;

    assign w_done_rise    = bus.done & ~r_done_ff;
    assign w_int          = r_int_sync[1];
    assign w_unused_rd_hi = ^bus.rd_data[15:8];

`ifdef INERT_TIMEOUT_EN
    logic [TO_W-1:0]    r_to_cnt;
    logic               r_to_err;

    assign w_to_hit = &r_to_cnt;
    assign to_err   = r_to_err;

    // Counter is zero on every WAIT_INT entry because any other state clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == S_WAIT && w_next == S_WAIT) ? r_to_cnt + 1'b1 : '0;
            if (w_to_set) r_to_err <= 1'b1;
        end
    end
`else
    assign w_to_hit = 1'b0;
    assign to_err   = 1'b0;
`endif

    always_comb begin
        w_next    = r_state;
        w_wrt     = 1'b0;
        w_cmd     = r_cmd;
        w_lo_ld   = 1'b0;
        w_yaw_ld  = 1'b0;
        w_cfg_set = 1'b0;
        w_cfg_clr = 1'b0;
        w_to_set  = 1'b0;
        case (r_state)
            S_PWR: begin
                if (&r_pwr_cnt) begin
                    w_wrt  = 1'b1;
                    w_cmd  = CFG0;
                    w_next = S_CFG0;
                end
            end
            S_CFG0: begin
                if (w_done_rise) begin
                    w_wrt  = 1'b1;
                    w_cmd  = CFG1;
                    w_next = S_CFG1;
                end
            end
            S_CFG1: begin
                if (w_done_rise) begin
                    w_wrt  = 1'b1;
                    w_cmd  = CFG2;
                    w_next = S_CFG2;
                end
            end
            S_CFG2: begin
                if (w_done_rise) begin
                    w_cfg_set = 1'b1;
                    w_next    = S_WAIT;
                end
            end
            S_WAIT: begin
                // A pending data-ready always wins over the watchdog.
                if (w_int) begin
                    w_wrt  = 1'b1;
                    w_cmd  = RD_LO;
                    w_next = S_RD_L;
                end else if (w_to_hit) begin
                    w_to_set  = 1'b1;
                    w_cfg_clr = 1'b1;
                    w_next    = S_PWR;
                end
            end
            S_RD_L: begin
                if (w_done_rise) begin
                    w_lo_ld = 1'b1;
                    w_wrt   = 1'b1;
                    w_cmd   = RD_HI;
                    w_next  = S_RD_H;
                end
            end
            S_RD_H: begin
                if (w_done_rise) begin
                    w_yaw_ld = 1'b1;
                    w_next   = S_WAIT;
                end
            end
            default: w_next = S_PWR;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_PWR;
            r_pwr_cnt  <= '0;
            r_int_sync <= 2'b00;
            r_done_ff  <= 1'b1;
            r_wrt      <= 1'b0;
            r_cmd      <= 16'h0000;
            r_lo       <= 8'h00;
            r_yaw      <= 16'h0000;
            r_vld      <= 1'b0;
            r_cfg_done <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_pwr_cnt  <= (r_state == S_PWR && w_next == S_PWR) ? r_pwr_cnt + 1'b1 : '0;
            r_int_sync <= {r_int_sync[0], INT};
            r_done_ff  <= bus.done;
            r_wrt      <= w_wrt;
            r_cmd      <= w_cmd;
            r_vld      <= w_yaw_ld;
            if (w_lo_ld)  r_lo  <= bus.rd_data[7:0];
            if (w_yaw_ld) r_yaw <= {bus.rd_data[7:0], r_lo};
            if (w_cfg_set)      r_cfg_done <= 1'b1;
            else if (w_cfg_clr) r_cfg_done <= 1'b0;
        end
    end

    assign bus.wrt  = r_wrt;
    assign bus.cmd  = r_cmd;
    assign yaw_rt   = r_yaw;
    assign vld      = r_vld;
    assign cfg_done = r_cfg_done;

endmodule

`default_nettype wire

// File: tb/tb_inert_spi_seq.sv
// ============================================================================
// Module : tb_inert_spi_seq
// Brief  : Directed bench with an SPI slave model and cmd/yaw scoreboards.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_inert_spi_seq;
    localparam logic [15:0] C0 = 16'h0D02;
    localparam logic [15:0] C1 = 16'h1160;
    localparam logic [15:0] C2 = 16'h1460;
    localparam logic [15:0] RL = 16'hA600;
    localparam logic [15:0] RH = 16'hA700;
    localparam int          LAT = 5;
    localparam int          PWR_CYC = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        cfg_done;
    logic        to_err;

    inert_spi_seq_if bus();

    always #5 clk = ~clk;

    inert_spi_seq #(
        .PWR_W(4)
`ifdef INERT_TIMEOUT_EN
        , .TO_W(8)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .INT(INT),
        .bus(bus),
        .yaw_rt(yaw_rt),
        .vld(vld),
        .cfg_done(cfg_done),
        .to_err(to_err)
    );

    int          n_pass = 0;
    int          n_total = 0;
    int          cyc = 0;
    int          hi_rise_cyc = -1;
    int          first_wrt_cyc = -1;
    int          rl_wrt_cyc[$];
    logic [15:0] exp_cmd[$];
    logic [15:0] exp_yaw[$];
    logic [7:0]  resp[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // SPI slave model: done drops the cycle after wrt, rises LAT cycles later.
    initial begin : slave
        logic        busy;
        int          cnt;
        logic [15:0] cur;
        logic [7:0]  b;
        busy = 1'b0; cnt = 0; cur = 16'h0; b = 8'h0;
        bus.done = 1'b1;
        bus.rd_data = 16'h0000;
        forever begin
            @(posedge clk); #1;
            if (rst) begin
                busy = 1'b0; cnt = 0; bus.done = 1'b1;
            end else if (bus.wrt) begin
                chk("wrt_idle", busy, 1'b0);
                chk("cmd_pending", exp_cmd.size() > 0, 1'b1);
                if (exp_cmd.size() > 0) chk("cmd", bus.cmd, exp_cmd.pop_front());
                if (first_wrt_cyc < 0) first_wrt_cyc = cyc;
                if (bus.cmd == RL) rl_wrt_cyc.push_back(cyc);
                busy = 1'b1; cnt = 0; cur = bus.cmd;
            end else if (busy) begin
                cnt++;
                if (cnt == 1) bus.done = 1'b0;
                if (cnt == LAT) begin
                    b = ((cur == RL || cur == RH) && resp.size() > 0) ? resp.pop_front() : 8'h00;
                    bus.rd_data = {8'hA5, b};
                    bus.done = 1'b1;
                    busy = 1'b0;
                    if (cur == RH) hi_rise_cyc = cyc;
                end
            end
        end
    end

    initial begin : mon
        forever begin
            @(posedge clk); #2;
            if (vld) begin
                chk("vld_latency", cyc, hi_rise_cyc + 1);
                chk("vld_expected", exp_yaw.size() > 0, 1'b1);
                if (exp_yaw.size() > 0) chk("yaw_rt", yaw_rt, exp_yaw.pop_front());
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cfg(input string tag);
        int n = 0;
        while (!cfg_done && n < 300) begin @(posedge clk); #1; n++; end
        chk(tag, cfg_done, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_cmd.size() != 0 || exp_yaw.size() != 0) && n < 300) begin
            @(posedge clk); #1; n++;
        end
        chk(tag, exp_cmd.size() + exp_yaw.size(), 0);
        repeat (10) @(posedge clk);
        #1;
    endtask

    initial begin : main
        int rel;
        int cfg_cyc;
        int t;
        int n;
        rst = 1'b1; INT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_wrt", bus.wrt, 1'b0);
        chk("rst_cmd", bus.cmd, 16'h0000);
        chk("rst_yaw", yaw_rt, 16'h0000);
        chk("rst_vld", vld, 1'b0);
        chk("rst_cfg_done", cfg_done, 1'b0);
        chk("rst_to_err", to_err, 1'b0);

        // 1: power-up wait then three config writes
        exp_cmd.push_back(C0); exp_cmd.push_back(C1); exp_cmd.push_back(C2);
        rst = 1'b0; rel = cyc;
        wait_cfg("t1_cfg_done");
        // first edge after release is cycle 0; wrt visible after cycle 15
        chk("t1_first_wrt_cyc", first_wrt_cyc, rel + 1 + PWR_CYC);
        chk("t1_cfg_cmds_used", exp_cmd.size(), 0);

        // 2: single read pair, positive sample
        resp.push_back(8'h34); resp.push_back(8'h12);
        exp_cmd.push_back(RL); exp_cmd.push_back(RH);
        exp_yaw.push_back(16'h1234);
        INT = 1'b1;
        repeat (2) @(posedge clk);
        #1; INT = 1'b0;
        wait_idle("t2_idle");
        chk("t2_yaw_hold", yaw_rt, 16'h1234);

        // 3: negative sample, INT held for back-to-back pairs
        repeat (2) begin resp.push_back(8'h80); resp.push_back(8'hFF); end
        repeat (2) begin
            exp_cmd.push_back(RL); exp_cmd.push_back(RH); exp_yaw.push_back(16'hFF80);
        end
        rl_wrt_cyc.delete();
        INT = 1'b1;
        n = 0;
        while (exp_yaw.size() != 1 && n < 300) begin @(posedge clk); #1; n++; end
        t = hi_rise_cyc;
        INT = 1'b0;
        wait_idle("t3_idle");
        chk("t3_two_pairs", rl_wrt_cyc.size(), 2);
        if (rl_wrt_cyc.size() == 2) chk("t3_back_to_back", rl_wrt_cyc[1], t + 2);

        // 4: INT high from reset, read only after config completes
        rst = 1'b1; INT = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        exp_cmd.push_back(C0); exp_cmd.push_back(C1); exp_cmd.push_back(C2);
        exp_cmd.push_back(RL); exp_cmd.push_back(RH);
        resp.push_back(8'h01); resp.push_back(8'h00);
        exp_yaw.push_back(16'h0001);
        first_wrt_cyc = -1;
        rl_wrt_cyc.delete();
        rst = 1'b0; rel = cyc;
        wait_cfg("t4_cfg_done");
        cfg_cyc = cyc;
        n = 0;
        while (rl_wrt_cyc.size() == 0 && n < 50) begin @(posedge clk); #1; n++; end
        INT = 1'b0;
        chk("t4_first_wrt_cyc", first_wrt_cyc, rel + 1 + PWR_CYC);
        chk("t4_rd_issued", rl_wrt_cyc.size(), 1);
        if (rl_wrt_cyc.size() > 0) chk("t4_rd_after_cfg", rl_wrt_cyc[0], cfg_cyc + 1);
        wait_idle("t4_idle");

        // 5: reset while the high-byte read is outstanding
        exp_cmd.push_back(RL); exp_cmd.push_back(RH);
        resp.push_back(8'h55); resp.push_back(8'h66);
        INT = 1'b1;
        repeat (2) @(posedge clk);
        #1; INT = 1'b0;
        n = 0;
        while (exp_cmd.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("t5_rh_issued", exp_cmd.size(), 0);
        repeat (2) @(posedge clk);
        #3; rst = 1'b1;
        #1;
        chk("t5_rst_wrt", bus.wrt, 1'b0);
        chk("t5_rst_vld", vld, 1'b0);
        chk("t5_rst_cfg_done", cfg_done, 1'b0);
        chk("t5_rst_yaw", yaw_rt, 16'h0000);
        resp.delete();
        repeat (3) @(posedge clk);
        #1;
        exp_cmd.push_back(C0); exp_cmd.push_back(C1); exp_cmd.push_back(C2);
        first_wrt_cyc = -1;
        rst = 1'b0; rel = cyc;
        wait_cfg("t5_cfg_redone");
        cfg_cyc = cyc;
        chk("t5_first_wrt_cyc", first_wrt_cyc, rel + 1 + PWR_CYC);

        // 6: no INT after config
`ifdef INERT_TIMEOUT_EN
        exp_cmd.push_back(C0); exp_cmd.push_back(C1); exp_cmd.push_back(C2);
        n = 0;
        while (!to_err && n < 400) begin @(posedge clk); #1; n++; end
        chk("t6_to_err", to_err, 1'b1);
        chk("t6_cfg_dropped", cfg_done, 1'b0);
        // WAIT_INT entered at cfg_cyc; counter 0..255 spans 256 cycles before the flag
        chk("t6_timeout_cyc", cyc, cfg_cyc + 256);
        wait_cfg("t6_cfg_replay");
        chk("t6_replay_cmds", exp_cmd.size(), 0);
        chk("t6_to_err_sticky", to_err, 1'b1);
`else
        repeat (400) @(posedge clk);
        #1;
        chk("t6_no_to_err", to_err, 1'b0);
        chk("t6_cfg_kept", cfg_done, 1'b1);
        chk("t6_no_stray_cmds", exp_cmd.size(), 0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
